// File: rtl/bbs_multibit.sv
// Blum-Blum-Shub generator producing K bits per step over a valid/ready stream.
// Each step computes x <- x^2 mod N with two radix-2 Montgomery multiplies:
// MM(x,x) = x^2*R^-1, then MM(T,C) with C = R^2 mod N gives x^2 mod N.
// Optional feature macro: BBS_ZERO_DETECT_EN (halt with err on x in {0,1}).
module bbs_multibit #(
    parameter int unsigned M  = 1024,
    parameter int unsigned K  = 1,
    parameter int unsigned NW = $clog2(M) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          start,
    input  logic [M-1:0]  seed,
    input  logic [M-1:0]  N,
    input  logic [M-1:0]  C,
    input  logic [NW-1:0] n,
    output logic          busy,
    output logic [K-1:0]  out_bits,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err
);

    // Accumulator width: S < 2N and S + B + N < 4N during an iteration.
    localparam int unsigned SW = M + 2;

    typedef enum logic [2:0] {
        IDLE,
        MUL1,
        FIX1,
        MUL2,
        FIX2,
        WAIT,
        HALT
    } state_t;

    state_t          state_q;
    logic [M-1:0]    x_q;
    logic [M-1:0]    mod_q;
    logic [M-1:0]    c_q;
    logic [NW-1:0]   nbits_q;
    logic [SW-1:0]   s_q;
    logic [M-1:0]    a_sh_q;
    logic [NW-1:0]   idx_q;
    logic            loaded_q;

    logic [SW-1:0]   b_op;
    logic [SW-1:0]   t_sum;
    logic [SW-1:0]   u_sum;
    logic [SW-1:0]   s_next;
    logic            s_ge;
    logic [M-1:0]    fixed;
    logic [M-1:0]    emit_val;
    logic            idx_last;
    logic            load_ok;
    logic            can_emit;

    // Multiplicand: x during the squaring pass, C during the domain-exit pass.
    assign b_op     = (state_q == MUL2) ? SW'(c_q) : SW'(x_q);

    // One Montgomery iteration: add A[i]*B, make even by adding N, halve.
    assign t_sum    = s_q + (a_sh_q[0] ? b_op : '0);
    assign u_sum    = t_sum + (t_sum[0] ? SW'(mod_q) : '0);
    assign s_next   = u_sum >> 1;

    // Final conditional subtraction brings S from [0,2N) into [0,N).
    assign s_ge     = (s_q >= SW'(mod_q));
    assign fixed    = s_ge ? M'(s_q - SW'(mod_q)) : M'(s_q);

    // Value offered downstream: freshly corrected in FIX2, held in WAIT.
    assign emit_val = (state_q == FIX2) ? fixed : x_q;

    assign idx_last = (idx_q == (nbits_q - NW'(1)));
    assign load_ok  = (n != '0) && (n <= NW'(M));
    assign can_emit = !out_valid || out_ready;

`ifdef BBS_ZERO_DETECT_EN
    logic degen;
    assign degen = (emit_val <= M'(1));
`else
    assign err = 1'b0;
`endif

    // Control FSM, Montgomery datapath registers and stream output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            mod_q     <= '0;
            c_q       <= '0;
            nbits_q   <= '0;
            s_q       <= '0;
            a_sh_q    <= '0;
            idx_q     <= '0;
            loaded_q  <= 1'b0;
            busy      <= 1'b0;
            out_bits  <= '0;
            out_valid <= 1'b0;
`ifdef BBS_ZERO_DETECT_EN
            err       <= 1'b0;
`endif
        end else begin
            // A consumed value with nothing new behind it empties the output.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_q)
                IDLE, HALT: begin
                    if (load && load_ok) begin
                        x_q       <= seed;
                        mod_q     <= N;
                        c_q       <= C;
                        nbits_q   <= n;
                        loaded_q  <= 1'b1;
                        out_valid <= 1'b0;
`ifdef BBS_ZERO_DETECT_EN
                        err       <= 1'b0;
`endif
                        state_q   <= IDLE;
                    end else if ((state_q == IDLE) && start && loaded_q) begin
                        s_q     <= '0;
                        idx_q   <= '0;
                        a_sh_q  <= x_q;
                        busy    <= 1'b1;
                        state_q <= MUL1;
                    end
                end

                MUL1, MUL2: begin
                    s_q    <= s_next;
                    a_sh_q <= a_sh_q >> 1;
                    idx_q  <= idx_q + NW'(1);
                    if (idx_last) begin
                        state_q <= (state_q == MUL1) ? FIX1 : FIX2;
                    end
                end

                FIX1: begin
                    a_sh_q  <= fixed;
                    s_q     <= '0;
                    idx_q   <= '0;
                    state_q <= MUL2;
                end

                FIX2, WAIT: begin
                    x_q <= emit_val;
`ifdef BBS_ZERO_DETECT_EN
                    if (degen) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= HALT;
                    end else
`endif
                    if (can_emit) begin
                        out_bits  <= emit_val[K-1:0];
                        out_valid <= 1'b1;
                        if (start) begin
                            s_q     <= '0;
                            idx_q   <= '0;
                            a_sh_q  <= emit_val;
                            state_q <= MUL1;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        state_q <= WAIT;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bbs_multibit.sv
// Self-checking bench for bbs_multibit (M=16, K=3) against an arithmetic model.
`timescale 1ns/1ps
module tb_bbs_multibit;

    localparam int unsigned M  = 16;
    localparam int unsigned K  = 3;
    localparam int unsigned NW = $clog2(M) + 1;
    localparam longint MASK    = (longint'(1) << K) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [M-1:0]  seed = '0;
    logic [M-1:0]  N = '0;
    logic [M-1:0]  C = '0;
    logic [NW-1:0] n = '0;
    logic          busy;
    logic [K-1:0]  out_bits;
    logic          out_valid;
    logic          err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bbs_multibit #(.M(M), .K(K), .NW(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .start     (start),
        .seed      (seed),
        .N         (N),
        .C         (C),
        .n         (n),
        .busy      (busy),
        .out_bits  (out_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic longint sq_mod(input longint x, input longint nm);
        return (x * x) % nm;
    endfunction

    function automatic longint r2_mod(input int nb, input longint nm);
        return (longint'(1) << (2 * nb)) % nm;
    endfunction

    // Pulse load for one edge with C derived from the model.
    task automatic do_load(input longint sd, input longint nm, input int nb);
        seed = M'(sd);
        N    = M'(nm);
        n    = NW'(nb);
        C    = M'(r2_mod(nb, nm));
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Advance at least one edge, then until out_valid or budget exhausted.
    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!out_valid && cyc < max);
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while ((busy || out_valid) && k < 200) begin
            tick();
            k++;
        end
        chk("drain_idle", busy, 0);
    endtask

    int     cyc;
    int     vcount;
    logic   stable;
    longint xm;
    longint nm_r;
    longint sd_r;
    int     nb_r;
    int     bl_r;
    int     got;
    int     first;
    logic   hv;
    logic [K-1:0] held;
    longint xs[8];
    logic   bad;

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_bits", out_bits, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        tick();

        // Start before any load must not launch.
        start = 1'b1;
        repeat (5) tick();
        chk("noload_busy", busy, 0);
        start = 1'b0;

        // Directed sequence N=77, n=7, seed=3: x = 9,4,16,25.
        do_load(3, 77, 7);
        out_ready = 1'b1;
        start = 1'b1;
        xm = 3;
        for (int s = 0; s < 4; s++) begin
            xm = sq_mod(xm, 77);
            wait_valid(100, cyc);
            chk("seq_valid", out_valid, 1);
            chk(s == 0 ? "first_latency" : "step_period", cyc, s == 0 ? 17 : 16);
            chk("seq_bits", out_bits, xm & MASK);
            chk("seq_busy", busy, 1);
        end
        start = 1'b0;
        drain();

        // Backpressure: hold ready low across more than a full step.
        do_load(3, 77, 7);
        start = 1'b1;
        wait_valid(100, cyc);
        chk("bp_first", out_bits, 1);
        out_ready = 1'b0;
        stable = 1'b1;
        repeat (40) begin
            tick();
            if (out_bits !== 3'd1 || out_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_hold", stable, 1);
        chk("bp_busy", busy, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", out_valid, 1);
        chk("bp_release_bits", out_bits, 4);
        wait_valid(100, cyc);
        chk("bp_after_period", cyc, 16);
        chk("bp_after_bits", out_bits, 0);
        start = 1'b0;
        drain();

        // Dropping start mid-step still completes and emits that step.
        do_load(3, 77, 7);
        start = 1'b1;
        repeat (5) tick();
        start = 1'b0;
        wait_valid(100, cyc);
        chk("stop_latency", cyc + 5, 17);
        chk("stop_bits", out_bits, 1);
        chk("stop_busy", busy, 0);
        vcount = 0;
        repeat (40) begin
            tick();
            if (out_valid) vcount++;
        end
        chk("stop_no_more", vcount, 0);

        // Load while busy is ignored; generation continues from x=9.
        start = 1'b1;
        repeat (3) tick();
        chk("lb_busy", busy, 1);
        do_load(5, 77, 7);
        wait_valid(100, cyc);
        chk("lb_bits0", out_bits, 4);
        wait_valid(100, cyc);
        chk("lb_bits1", out_bits, 0);
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of the second multiply.
        do_load(3, 77, 7);
        start = 1'b1;
        wait_valid(100, cyc);
        out_ready = 1'b0;
        repeat (12) tick();
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_bits", out_bits, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        vcount = 0;
        repeat (40) begin
            tick();
            if (out_valid || busy) vcount++;
        end
        chk("arst_needs_load", vcount, 0);
        start = 1'b0;

        // Degenerate seed x0 = 1.
        do_load(1, 77, 7);
        start = 1'b1;
`ifdef BBS_ZERO_DETECT_EN
        repeat (17) tick();
        chk("zd_err", err, 1);
        chk("zd_busy", busy, 0);
        vcount = 0;
        repeat (40) begin
            if (out_valid) vcount++;
            tick();
        end
        chk("zd_no_valid", vcount, 0);
        chk("zd_halt_busy", busy, 0);
        do_load(3, 77, 7);
        chk("zd_err_clear", err, 0);
        xm = 3;
        for (int s = 0; s < 4; s++) begin
            xm = sq_mod(xm, 77);
            wait_valid(100, cyc);
            chk("zd_resume_valid", out_valid, 1);
            chk("zd_resume_bits", out_bits, xm & MASK);
        end
`else
        for (int s = 0; s < 2; s++) begin
            wait_valid(100, cyc);
            chk("deg_valid", out_valid, 1);
            chk("deg_bits", out_bits, 1);
            chk("deg_err", err, 0);
        end
`endif
        start = 1'b0;
        drain();

        // Randomized moduli, seeds and consumer backpressure.
        for (int tr = 0; tr < 6; tr++) begin
            bad = 1'b1;
            for (int t = 0; t < 100 && bad; t++) begin
                nm_r = longint'($urandom_range(65535, 5)) | 1;
                bl_r = 1;
                while ((longint'(1) << bl_r) <= nm_r) bl_r++;
                nb_r = int'($urandom_range(16, bl_r));
                sd_r = longint'($urandom_range(32'(nm_r - 1), 2));
                xm = sd_r;
                bad = 1'b0;
                for (int s = 0; s < 8; s++) begin
                    xm = sq_mod(xm, nm_r);
                    xs[s] = xm;
                    if (xm < 2) bad = 1'b1;
                end
            end
            do_load(sd_r, nm_r, nb_r);
            start = 1'b1;
            out_ready = 1'b0;
            got = 0;
            cyc = 0;
            first = -1;
            hv = 1'b0;
            held = '0;
            while (got < 4 && cyc < 2000) begin
                if (out_valid) begin
                    if (first < 0) begin
                        first = cyc;
                        chk("rand_latency", first, 2 * nb_r + 3);
                    end
                    if (hv) chk("rand_stable", out_bits, held);
                    out_ready = 1'($urandom_range(1, 0));
                    if (out_ready) begin
                        chk("rand_bits", out_bits, xs[got] & MASK);
                        got++;
                        hv = 1'b0;
                    end else begin
                        held = out_bits;
                        hv = 1'b1;
                    end
                end else begin
                    if (hv) chk("rand_valid_drop", out_valid, 1);
                    out_ready = 1'($urandom_range(1, 0));
                    hv = 1'b0;
                end
                tick();
                cyc++;
            end
            chk("rand_count", got, 4);
            start = 1'b0;
            out_ready = 1'b1;
            cyc = 0;
            while ((busy || out_valid) && cyc < 200) begin
                if (out_valid && got < 8) begin
                    chk("rand_tail_bits", out_bits, xs[got] & MASK);
                    got++;
                end
                tick();
                cyc++;
            end
            chk("rand_idle", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
